pipeline_ctrl: RTL

//  Central sequencer for the PC -> IM -> IF_ID -> ID/RF -> ID_EXE -> EXE pipeline. It drives the
//  PC and pipeline-buffer enables, stalls on RAW hazards via a register scoreboard, freezes on

---
 rtl/pipeline_ctrl_if.sv | 45 ++++
 rtl/pipeline_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its central sequencer.
// The datapath side (master) reports decode/execute/writeback status; the
// sequencer side (slave) returns PC and pipeline-buffer controls.
interface pipeline_ctrl_if #(
  parameter int RFW = 5,
  parameter int SCW = 16
);
  logic           run;
  logic           id_valid;
  logic [RFW-1:0] id_rs1;
  logic [RFW-1:0] id_rs2;
  logic           id_use_rs1;
  logic           id_use_rs2;
  logic [RFW-1:0] id_rd;
  logic           id_wr;
  logic           id_halt;
  logic           exe_busy;
  logic           exe_br_taken;
  logic           wb_valid;
  logic [RFW-1:0] wb_rd;

  logic           pc_we;
  logic           pc_sel;
  logic           if_id_en;
  logic           if_id_flush;
  logic           id_exe_en;
  logic           id_exe_bubble;
  logic           halted;
  logic [2:0]     state;
  logic [SCW-1:0] stall_cnt;

  modport master (
    output run, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr,
           id_halt, exe_busy, exe_br_taken, wb_valid, wb_rd,
    input  pc_we, pc_sel, if_id_en, if_id_flush, id_exe_en, id_exe_bubble,
           halted, state, stall_cnt
  );

  modport slave (
    input  run, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr,
           id_halt, exe_busy, exe_br_taken, wb_valid, wb_rd,
    output pc_we, pc_sel, if_id_en, if_id_flush, id_exe_en, id_exe_bubble,
           halted, state, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the PC -> IM -> IF_ID -> ID/RF -> ID_EXE -> EXE pipe.
// Tracks in-flight register writes in a scoreboard to stall RAW hazards,
// freezes on multi-cycle EXE ops, flushes on taken branches and drains the
// pipe into a halt state. Control outputs are decoded combinationally from
// the registered state and the current pipeline status.
module pipeline_ctrl #(
  parameter int RFW = 5,
  parameter int SCW = 16
) (
  input logic             clk,
  input logic             start,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    HALT  = 3'd3
  } state_t;

  localparam int NREG = 2 ** RFW;

  state_t            cur;
  logic [NREG-1:0]   sb;
  logic [SCW-1:0]    stall;

  logic              raw;
  logic              issue;
  logic              stall_inc;
  logic              halt_go;
  logic [NREG-1:0]   sb_next;

  // RAW hazard: a source actually read by the ID instruction is still pending.
  always_comb begin
    raw = bus.id_valid &&
          ((bus.id_use_rs1 && sb[bus.id_rs1]) || (bus.id_use_rs2 && sb[bus.id_rs2]));
  end

  // Decode the per-cycle control outputs from the state and the priority chain.
  always_comb begin
    bus.pc_we         = 1'b0;
    bus.pc_sel        = 1'b0;
    bus.if_id_en      = 1'b0;
    bus.if_id_flush   = 1'b0;
    bus.id_exe_en     = 1'b0;
    bus.id_exe_bubble = 1'b0;
    bus.halted        = 1'b0;
    issue             = 1'b0;
    stall_inc         = 1'b0;
    halt_go           = 1'b0;
    case (cur)
      RUN: begin
        if (bus.exe_br_taken) begin
          bus.pc_we         = 1'b1;
          bus.pc_sel        = 1'b1;
          bus.if_id_en      = 1'b1;
          bus.if_id_flush   = 1'b1;
          bus.id_exe_en     = 1'b1;
          bus.id_exe_bubble = 1'b1;
        end else if (bus.exe_busy) begin
          stall_inc = 1'b1;
        end else if (raw) begin
          bus.id_exe_en     = 1'b1;
          bus.id_exe_bubble = 1'b1;
          stall_inc         = 1'b1;
        end else if (bus.id_valid && bus.id_halt) begin
          bus.id_exe_en     = 1'b1;
          bus.id_exe_bubble = 1'b1;
          halt_go           = 1'b1;
        end else begin
          bus.pc_we     = 1'b1;
          bus.if_id_en  = 1'b1;
          bus.id_exe_en = 1'b1;
          issue         = 1'b1;
        end
      end
      DRAIN: begin
        // A taken branch here means the HALT was on the wrong path.
        if (bus.exe_br_taken) begin
          bus.pc_we         = 1'b1;
          bus.pc_sel        = 1'b1;
          bus.if_id_en      = 1'b1;
          bus.if_id_flush   = 1'b1;
          bus.id_exe_en     = 1'b1;
          bus.id_exe_bubble = 1'b1;
        end else begin
          bus.id_exe_en     = 1'b1;
          bus.id_exe_bubble = 1'b1;
        end
      end
      HALT: begin
        bus.halted = 1'b1;
      end
      default: begin
        bus.halted = 1'b0;
      end
    endcase
  end

  // Scoreboard update: retire clears first, then an issuing write sets (set wins).
  always_comb begin
    sb_next = sb;
    if (bus.wb_valid) begin
      sb_next[bus.wb_rd] = 1'b0;
    end else begin
      sb_next = sb_next;
    end
    if (issue && bus.id_valid && bus.id_wr && (bus.id_rd != {RFW{1'b0}})) begin
      sb_next[bus.id_rd] = 1'b1;
    end else begin
      sb_next = sb_next;
    end
  end

  // Sequencer state, scoreboard and saturating stall counter.
  always_ff @(posedge clk) begin
    if (start) begin
      cur   <= IDLE;
      sb    <= {NREG{1'b0}};
      stall <= {SCW{1'b0}};
    end else begin
      case (cur)
        IDLE: begin
          if (bus.run) cur <= RUN;
        end
        RUN: begin
          sb <= sb_next;
          if (stall_inc && (stall != {SCW{1'b1}})) begin
            stall <= stall + {{(SCW-1){1'b0}}, 1'b1};
          end
          if (halt_go) cur <= DRAIN;
        end
        DRAIN: begin
          sb <= sb_next;
          // The drain check uses the registered scoreboard, so a retire
          // becomes visible one cycle later.
          if (bus.exe_br_taken) begin
            cur <= RUN;
          end else if ((sb == {NREG{1'b0}}) && !bus.exe_busy) begin
            cur <= HALT;
          end
        end
        HALT: begin
          cur <= HALT;
        end
        default: begin
          cur <= IDLE;
        end
      endcase
    end
  end

  assign bus.state     = cur;
  assign bus.stall_cnt = stall;

endmodule
